rpsc_card_1: RTL and testbench

RPSC_CARD_1 -- requirements
Module: rpsc_card_1

---
 rtl/rpsc_card_pkg.sv | 18 +
 rtl/rpsc_card_1_delay_timer.sv | 36 +++
 rtl/rpsc_card_1.sv | 85 ++++++++
 tb/tb_rpsc_card_1.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpsc_card_pkg.sv
// Shared constants for the RPSC card: clock period, delay targets and counter sizing.
package rpsc_card_pkg;

  localparam int CLK_PERIOD_NS = 1280;

  localparam int T4_FULL   = 3125000;
  localparam int T60_FULL  = 46875000;
  localparam int T4_SHORT  = 15;
  localparam int T60_SHORT = 31;

  // Bits needed to hold 0..target; never less than one so a zero target still builds.
  function automatic int cnt_width(input int target);
    int w;
    w = $clog2(target + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rpsc_card_1_delay_timer.sv
// On-delay timer: output follows input once it has been high for `target` consecutive edges.
// Counter saturates at target; any low cycle clears it.
module delay_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             in,
  output logic             hit_target
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!in) begin
      count_d = '0;
    end else if (count_q != target) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Gated by reset so a zero target cannot leak the input through while held in reset.
  assign hit_target = reset & in & (count_q == target);

endmodule

// File: rtl/rpsc_card_1.sv
// RPSC card logic: fan/status/control gating plus 4 s and 60 s CA on-delays.
// Define RPSC_SHORT_TIMERS_EN to default the delays to 15/31 cycles for simulation.
module rpsc_card_1
  import rpsc_card_pkg::*;
#(
`ifdef RPSC_SHORT_TIMERS_EN
  parameter int T4_TARGET  = T4_SHORT,
  parameter int T60_TARGET = T60_SHORT
`else
  parameter int T4_TARGET  = T4_FULL,
  parameter int T60_TARGET = T60_FULL
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i17_FAN_ON_PERM,
  input  logic i18_FAN_ACT,
  input  logic i51_Card_POS,
  input  logic i50_Air_Grid,
  input  logic i49_Water_Anode,
  input  logic i48_Water_Grid,
  input  logic i46_DC_PS,
  input  logic i45_U_CA_Low,
  input  logic i44_I_CA_High,
  input  logic i53_Not_G1_OK,
  input  logic i54_FAN_ON,
  input  logic i59_CA_PS_ACT,
  input  logic i72_I_CA_High,
  input  logic i76_U_CA_Low,
  output logic o14_FAN_ON_PERM,
  output logic o19_FAN_ON,
  output logic o55_Not_Alarm,
  output logic o47_CA_ON_PERM,
  output logic o78_Modified,
  output logic o62_CA_ON,
  output logic o74_CA_Delay,
  output logic o75_Not_CA_OK,
  output logic o70_I_CA_High,
  output logic o77_U_CA_Low
);

  localparam int W4  = cnt_width(T4_TARGET);
  localparam int W60 = cnt_width(T60_TARGET);

  logic nor_status;
  logic nor_control;
  logic and_control;
  logic on_4s;
  logic on_60s;

  assign nor_status = ~(i51_Card_POS | i50_Air_Grid | i49_Water_Anode | i48_Water_Grid |
                        i46_DC_PS | i45_U_CA_Low | i44_I_CA_High);
  assign nor_control = ~(i53_Not_G1_OK | i54_FAN_ON | ~nor_status);
  assign and_control = nor_control & i59_CA_PS_ACT;

  assign o14_FAN_ON_PERM = ~i17_FAN_ON_PERM;
  assign o19_FAN_ON      = ~i18_FAN_ACT;
  assign o62_CA_ON       = ~i59_CA_PS_ACT;
  assign o55_Not_Alarm   = nor_status;
  assign o78_Modified    = nor_control;
  assign o47_CA_ON_PERM  = ~nor_control;

  // The 60 s delay only starts counting once the 4 s permit is already up.
  delay_timer #(.WIDTH(W4)) u_timer_4s (
    .clk        (clk),
    .reset      (reset),
    .target     (W4'(T4_TARGET)),
    .in         (and_control),
    .hit_target (on_4s)
  );

  delay_timer #(.WIDTH(W60)) u_timer_60s (
    .clk        (clk),
    .reset      (reset),
    .target     (W60'(T60_TARGET)),
    .in         (on_4s),
    .hit_target (on_60s)
  );

  assign o74_CA_Delay  = on_60s;
  assign o75_Not_CA_OK = ~(on_4s & on_60s);
  assign o70_I_CA_High = ~(on_4s & i72_I_CA_High);
  assign o77_U_CA_Low  = ~(on_4s & i76_U_CA_Low);

endmodule

// File: tb/tb_rpsc_card_1.sv
// Bench for rpsc_card_1 with short delay targets: vector table, scripted delay sequences, random vs model.
module tb_rpsc_card_1;
  import rpsc_card_pkg::*;

  localparam int T4  = T4_SHORT;
  localparam int T60 = T60_SHORT;

  logic clk = 1'b0;
  logic reset;
  // {i17,i18,i51,i50,i49,i48,i46,i45,i44,i53,i54,i59,i72,i76}
  logic [13:0] stim;
  logic o14, o19, o55, o47, o78, o62, o74, o75, o70, o77;
  logic [9:0] dut_o;

  int n_cmp = 0;
  int n_bad = 0;
  int m_run4 = 0;
  int m_run60 = 0;

  always #5 clk = ~clk;

  rpsc_card_1 #(.T4_TARGET(T4), .T60_TARGET(T60)) dut (
    .clk             (clk),
    .reset           (reset),
    .i17_FAN_ON_PERM (stim[13]),
    .i18_FAN_ACT     (stim[12]),
    .i51_Card_POS    (stim[11]),
    .i50_Air_Grid    (stim[10]),
    .i49_Water_Anode (stim[9]),
    .i48_Water_Grid  (stim[8]),
    .i46_DC_PS       (stim[7]),
    .i45_U_CA_Low    (stim[6]),
    .i44_I_CA_High   (stim[5]),
    .i53_Not_G1_OK   (stim[4]),
    .i54_FAN_ON      (stim[3]),
    .i59_CA_PS_ACT   (stim[2]),
    .i72_I_CA_High   (stim[1]),
    .i76_U_CA_Low    (stim[0]),
    .o14_FAN_ON_PERM (o14),
    .o19_FAN_ON      (o19),
    .o55_Not_Alarm   (o55),
    .o47_CA_ON_PERM  (o47),
    .o78_Modified    (o78),
    .o62_CA_ON       (o62),
    .o74_CA_Delay    (o74),
    .o75_Not_CA_OK   (o75),
    .o70_I_CA_High   (o70),
    .o77_U_CA_Low    (o77)
  );

  assign dut_o = {o14, o19, o55, o47, o78, o62, o74, o75, o70, o77};

  typedef struct packed {
    logic [13:0] in;
    logic [9:0]  exp;
  } vec_t;

  // Reference: the 4 s permit is up when CA enable has been high for T4 straight edges,
  // the 60 s delay when the permit has been up for T60 straight edges.
  function automatic logic [9:0] model_out(logic [13:0] s, logic rst_n, int r4, int r60);
    logic fault, ctl_ok, en, on4, on60;
    fault  = |s[11:5];
    ctl_ok = !(s[4] || s[3] || fault);
    en     = ctl_ok && s[2];
    on4    = rst_n && en && (r4 >= T4);
    on60   = on4 && (r60 >= T60);
    return {!s[13], !s[12], !fault, !ctl_ok, ctl_ok, !s[2], on60, !(on4 && on60),
            !(on4 && s[1]), !(on4 && s[0])};
  endfunction

  task automatic model_edge();
    logic fault, en, on4_before;
    if (!reset) begin
      m_run4 = 0;
      m_run60 = 0;
    end else begin
      fault = |stim[11:5];
      en = !(stim[4] || stim[3] || fault) && stim[2];
      on4_before = en && (m_run4 >= T4);
      m_run4  = en ? ((m_run4 + 1 > T4) ? T4 : m_run4 + 1) : 0;
      m_run60 = on4_before ? ((m_run60 + 1 > T60) ? T60 : m_run60 + 1) : 0;
    end
  endtask

  task automatic chk_vec(string name, logic [9:0] got, logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_bit(string name, logic got, logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One rising edge; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    m_run4 = 0;
    m_run60 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    assert_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  vec_t table_v[8];

  initial begin
    logic noisy;
    reset = 1'b0;
    stim  = '0;

    // Timers idle: outputs o74/o75/o70/o77 stay 0/1/1/1 throughout.
    table_v[0] = '{in: 14'b00000000000000, exp: 10'b1110110111};
    table_v[1] = '{in: 14'b11000000000000, exp: 10'b0010110111};
    table_v[2] = '{in: 14'b00000000000100, exp: 10'b1110100111};
    table_v[3] = '{in: 14'b00000000010100, exp: 10'b1111000111};
    table_v[4] = '{in: 14'b00000000001000, exp: 10'b1111010111};
    table_v[5] = '{in: 14'b00100000000000, exp: 10'b1101010111};
    table_v[6] = '{in: 14'b00000000100100, exp: 10'b1101000111};
    table_v[7] = '{in: 14'b00000000000111, exp: 10'b1110100111};

    // Pass 0 held in reset, pass 1 running: the same constants apply to both.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      reset = (pass == 1);
      for (int i = 0; i < 8; i++) begin
        stim = table_v[i].in;
        #1;
        chk_vec($sformatf("table_p%0d_v%0d", pass, i), dut_o, table_v[i].exp);
        tick();
      end
    end

    // Clean enable: permit after T4 edges, CA delay after T4+T60; i72 high exposes on_4s on o70.
    do_reset();
    stim = 14'b00000000000110;
    #1;
    chk_bit("seqA_o62_start", o62, 1'b0);
    chk_bit("seqA_o78_start", o78, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk_bit($sformatf("seqA_o70_e%0d", k), o70, !(k >= T4));
      chk_bit($sformatf("seqA_o74_e%0d", k), o74, (k >= T4 + T60));
      chk_bit($sformatf("seqA_o75_e%0d", k), o75, !(k >= T4 + T60));
    end
    stim[0] = 1'b1;
    #1;
    chk_bit("seqA_o77_fault", o77, 1'b0);
    stim[2] = 1'b0;
    #1;
    chk_bit("seqA_o74_drop", o74, 1'b0);
    chk_bit("seqA_o75_drop", o75, 1'b1);
    chk_bit("seqA_o62_drop", o62, 1'b1);
    chk_bit("seqA_o70_drop", o70, 1'b1);
    chk_bit("seqA_o77_drop", o77, 1'b1);
    tick();

    // Single-cycle air-grid fault at edge 10 restarts the permit count.
    do_reset();
    stim = 14'b00000000000100;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) begin
        stim[10] = 1'b1;
        #1;
        chk_bit("seqB_o55_pulse", o55, 1'b0);
      end
      tick();
      if (k == 10) stim[10] = 1'b0;
      if (k >= 50) chk_bit($sformatf("seqB_o74_e%0d", k), o74, (k >= 56));
    end

    // Reset mid-count at edge 20 drops everything at once and restarts from zero.
    do_reset();
    stim = 14'b00000000000110;
    for (int k = 1; k <= 20; k++) tick();
    chk_bit("seqC_o70_before", o70, 1'b0);
    assert_reset();
    #1;
    chk_bit("seqC_o70_rst", o70, 1'b1);
    chk_bit("seqC_o74_rst", o74, 1'b0);
    chk_bit("seqC_o75_rst", o75, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      chk_bit($sformatf("seqC_o70_e%0d", k), o70, !(k >= T4));
      chk_bit($sformatf("seqC_o74_e%0d", k), o74, (k >= T4 + T60));
    end

    // Fan feedback and G1 inhibit: permit withheld, timers never fire.
    do_reset();
    stim = 14'b11000000010110;
    #1;
    chk_bit("seqD_o14", o14, 1'b0);
    chk_bit("seqD_o19", o19, 1'b0);
    chk_bit("seqD_o47", o47, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (o74 !== 1'b0 || o70 !== 1'b1) begin
        chk_bit($sformatf("seqD_o74_e%0d", k), o74, 1'b0);
        chk_bit($sformatf("seqD_o70_e%0d", k), o70, 1'b1);
      end
    end
    chk_bit("seqD_o74_end", o74, 1'b0);

    // Random traffic against the model, alternating quiet and noisy segments.
    do_reset();
    noisy = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) noisy = ($urandom_range(0, 2) == 0);
      for (int b = 5; b <= 11; b++) stim[b] = ($urandom_range(0, noisy ? 15 : 400) == 0);
      stim[4]  = ($urandom_range(0, noisy ? 15 : 400) == 0);
      stim[3]  = ($urandom_range(0, noisy ? 15 : 400) == 0);
      stim[2]  = ($urandom_range(0, noisy ? 3 : 200) != 0);
      stim[1]  = 1'($urandom_range(0, 1));
      stim[0]  = 1'($urandom_range(0, 1));
      stim[13] = 1'($urandom_range(0, 1));
      stim[12] = 1'($urandom_range(0, 1));
      if (!reset) begin
        if ($urandom_range(0, 3) == 0) reset = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        assert_reset();
      end
      #1;
      chk_vec($sformatf("rand_c%0d", cyc), dut_o, model_out(stim, reset, m_run4, m_run60));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
